// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request, operand, cancel, MTHI/MTLO and result signals
// shared between the execute stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO engine. Radix-2 shift-add multiplier and
// restoring divider working on operand magnitudes, with a final FIX cycle
// applying sign correction. One operation takes WIDTH+1 cycles.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t               state_r;
   logic [CNT_W-1:0]     count_r;
   logic                 isDiv_r;
   logic                 negRes_r;    // quotient / product must be negated
   logic                 negRem_r;    // remainder takes a negative dividend sign
   logic                 divZero_r;
   logic [WIDTH-1:0]     operand_r;   // multiplicand or divisor magnitude
   logic [WIDTH-1:0]     rawA_r;      // src_a as latched, returned as HI on /0
   logic [2*WIDTH-1:0]   acc_r;       // {partial product, multiplier} or {remainder, quotient}
   logic                 busy_r;
   logic                 done_r;
   logic                 dbz_r;
   logic [WIDTH-1:0]     hi_r;
   logic [WIDTH-1:0]     lo_r;

   logic [WIDTH:0]       mulSum_s;
   logic [2*WIDTH-1:0]   mulNext_s;
   logic [WIDTH:0]       divRem_s;
   logic [WIDTH+1:0]     divTrial_s;
   logic [2*WIDTH-1:0]   divNext_s;
   logic [2*WIDTH-1:0]   stepNext_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     fixHi_s;
   logic [WIDTH-1:0]     fixLo_s;

   // Two's-complement negation of a WIDTH-bit value.
   function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1'b1);
   endfunction

   // Absolute value for signed ops, raw value for unsigned ops.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic isSigned);
      if (isSigned && v[WIDTH-1]) begin
         return negW(v);
      end else begin
         return v;
      end
   endfunction

   // One iteration of either the shift-add multiply or the restoring divide.
   // The shifted remainder needs WIDTH+1 bits, so the trial subtraction
   // carries one more guard bit to expose its sign.
   always_comb begin
      mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                   (acc_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
      mulNext_s  = {mulSum_s, acc_r[WIDTH-1:1]};
      divRem_s   = acc_r[2*WIDTH-1:WIDTH-1];
      divTrial_s = {1'b0, divRem_s} - {2'b00, operand_r};
      if (divTrial_s[WIDTH+1]) begin
         divNext_s = {divRem_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
         divNext_s = {divTrial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
      if (isDiv_r) begin
         stepNext_s = divNext_s;
      end else begin
         stepNext_s = mulNext_s;
      end
   end

   // Sign correction and divide-by-zero substitution applied in FIX.
   always_comb begin
      fixHi_s = hi_r;
      fixLo_s = lo_r;
      if (negRes_r) begin
         prod_s = ~acc_r + (2*WIDTH)'(1'b1);
      end else begin
         prod_s = acc_r;
      end
      if (!isDiv_r) begin
         fixHi_s = prod_s[2*WIDTH-1:WIDTH];
         fixLo_s = prod_s[WIDTH-1:0];
      end else if (divZero_r) begin
         fixHi_s = rawA_r;
         fixLo_s = {WIDTH{1'b1}};
      end else begin
         fixLo_s = negRes_r ? negW(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
         fixHi_s = negRem_r ? negW(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         count_r   <= {CNT_W{1'b0}};
         isDiv_r   <= 1'b0;
         negRes_r  <= 1'b0;
         negRem_r  <= 1'b0;
         divZero_r <= 1'b0;
         operand_r <= {WIDTH{1'b0}};
         rawA_r    <= {WIDTH{1'b0}};
         acc_r     <= {(2*WIDTH){1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         dbz_r     <= 1'b0;
         hi_r      <= {WIDTH{1'b0}};
         lo_r      <= {WIDTH{1'b0}};
      end else begin
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start && !bus.cancel) begin
                  isDiv_r   <= bus.op[1];
                  negRes_r  <= bus.op[0] & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                  negRem_r  <= bus.op[0] & bus.op[1] & bus.src_a[WIDTH-1];
                  divZero_r <= bus.op[1] & (bus.src_b == {WIDTH{1'b0}});
                  operand_r <= magnitude(bus.src_b, bus.op[0]);
                  acc_r     <= {{WIDTH{1'b0}}, magnitude(bus.src_a, bus.op[0])};
                  rawA_r    <= bus.src_a;
                  count_r   <= CNT_W'(WIDTH);
                  busy_r    <= 1'b1;
                  state_r   <= CALC;
               end else if (!bus.start) begin
                  if (bus.hi_we) begin
                     hi_r <= bus.wdata;
                  end
                  if (bus.lo_we) begin
                     lo_r <= bus.wdata;
                  end
               end else begin
                  // start together with cancel: request refused, writes dropped
                  state_r <= IDLE;
               end
            end
            CALC: begin
               if (bus.cancel) begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  acc_r   <= stepNext_s;
                  count_r <= count_r - CNT_W'(1);
                  if (count_r == CNT_W'(1)) begin
                     state_r <= FIX;
                  end
               end
            end
            FIX: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
               if (!bus.cancel) begin
                  hi_r   <= fixHi_s;
                  lo_r   <= fixLo_s;
                  done_r <= 1'b1;
                  dbz_r  <= isDiv_r & divZero_r;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (native 64-bit multiply, divide and modulo).
module tb_muldiv_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on 64-bit integers.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eHi, output logic [31:0] eLo, output logic eDz);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      eDz = 1'b0;
      eHi = 32'h0;
      eLo = 32'h0;
      case (op)
         2'b00: begin p = 64'(a) * 64'(b); eHi = p[63:32]; eLo = p[31:0]; end
         2'b01: begin p = 64'(sa * sb);    eHi = p[63:32]; eLo = p[31:0]; end
         default: begin
            if (b == 32'h0) begin
               eLo = 32'hFFFF_FFFF; eHi = a; eDz = 1'b1;
            end else if (op == 2'b10) begin
               eLo = a / b; eHi = a % b;
            end else begin
               eLo = 32'(sa / sb); eHi = 32'(sa % sb);
            end
         end
      endcase
   endfunction

   // Present a request before an edge; afterwards scramble the operand bus.
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.src_a = 32'($urandom);
      bus.src_b = 32'($urandom);
   endtask

   // Follow an accepted op to its done cycle (returns inside it).
   task automatic complete(input string tag, input logic [31:0] eHi, input logic [31:0] eLo, input logic eDz);
      check({tag, " busy@E0"}, bus.busy, 1);
      repeat (W) begin @(posedge clk); #1; end
      check({tag, " no early done"}, bus.done, 0);
      check({tag, " busy@EW"}, bus.busy, 1);
      @(posedge clk); #1;
      check({tag, " done"}, bus.done, 1);
      check({tag, " busy in done"}, bus.busy, 0);
      check({tag, " hi"}, bus.hi, eHi);
      check({tag, " lo"}, bus.lo, eLo);
      check({tag, " dbz"}, bus.div_by_zero, eDz);
   endtask

   task automatic noDone(input string tag, input int cycles);
      int seen = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen++;
      end
      check({tag, " no done"}, seen, 0);
   endtask

   initial begin
      logic [31:0] eHi;
      logic [31:0] eLo;
      logic        eDz;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      reset = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'h0; bus.src_b = 32'h0;
      bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
      repeat (2) @(posedge clk); #1;
      check("rst busy", bus.busy, 0);
      check("rst done", bus.done, 0);
      check("rst dbz", bus.div_by_zero, 0);
      check("rst hi", bus.hi, 0);
      check("rst lo", bus.lo, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      complete("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      @(posedge clk); #1;
      check("done one cycle", bus.done, 0);

      launch(2'b01, 32'hFFFF_FFF9, 32'd3);
      complete("mult -7*3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      launch(2'b11, 32'hFFFF_FFF9, 32'd2);           // start in done cycle
      complete("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      launch(2'b10, 32'd100, 32'd7);
      complete("divu 100/7", 32'd2, 32'd14, 1'b0);
      launch(2'b10, 32'h1234, 32'h0);
      complete("divu /0", 32'h1234, 32'hFFFF_FFFF, 1'b1);
      @(posedge clk); #1;
      check("dbz one cycle", bus.div_by_zero, 0);
      launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      complete("div min/-1", 32'h0, 32'h8000_0000, 1'b0);
      launch(2'b11, 32'hFFFF_FFF0, 32'h0);
      complete("div neg/0", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
      @(posedge clk); #1;

      // MTLO / MTHI in IDLE
      bus.lo_we = 1'b1; bus.wdata = 32'h55;
      @(posedge clk); #1;
      bus.lo_we = 1'b0;
      check("mtlo", bus.lo, 32'h55);
      check("mtlo keeps hi", bus.hi, 32'hFFFF_FFF0);
      bus.hi_we = 1'b1; bus.wdata = 32'h1111_2222;
      @(posedge clk); #1;
      bus.hi_we = 1'b0;
      check("mthi", bus.hi, 32'h1111_2222);

      // start wins over a simultaneous MTHI
      bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      launch(2'b10, 32'd100, 32'd7);
      bus.hi_we = 1'b0;
      check("start beats mthi", bus.hi, 32'h1111_2222);
      complete("divu again", 32'd2, 32'd14, 1'b0);
      @(posedge clk); #1;

      // cancel at cycle 10, stray start at cycle 5, MTHI during CALC
      launch(2'b01, 32'd5, 32'd6);
      repeat (4) @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      bus.hi_we = 1'b0;
      check("mthi dropped busy", bus.hi, 32'd2);
      check("busy before cancel", bus.busy, 1);
      repeat (3) @(posedge clk); #1;
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      check("cancel busy", bus.busy, 0);
      check("cancel hi", bus.hi, 32'd2);
      check("cancel lo", bus.lo, 32'd14);
      noDone("after cancel", 40);
      check("no queued start", bus.busy, 0);

      // start with cancel in IDLE is refused
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b00; bus.src_a = 32'd3; bus.src_b = 32'd4;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      check("start+cancel refused", bus.busy, 0);
      noDone("start+cancel", 40);
      check("start+cancel lo", bus.lo, 32'd14);

      // async reset in the middle of a divide
      launch(2'b11, 32'hFFFF_FF9C, 32'd7);
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async rst busy", bus.busy, 0);
      check("async rst hi", bus.hi, 0);
      check("async rst lo", bus.lo, 0);
      @(negedge clk);
      reset = 1'b0;
      noDone("after reset", 40);
      bus.lo_we = 1'b1; bus.wdata = 32'h55;
      @(posedge clk); #1;
      bus.lo_we = 1'b0;
      check("mtlo after reset", bus.lo, 32'h55);

      // randomized ops, every other one started in the done cycle
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = 32'($urandom);
         rb  = 32'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 20));
            default: ;
         endcase
         model(rop, ra, rb, eHi, eLo, eDz);
         launch(rop, ra, rb);
         complete($sformatf("rnd%0d op%0d", i, rop), eHi, eLo, eDz);
         if ((i % 2) == 0) begin
            @(posedge clk); #1;
            check($sformatf("rnd%0d done drop", i), bus.done, 0);
            check($sformatf("rnd%0d dbz drop", i), bus.div_by_zero, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
